// File: rtl/adc_capture.sv
// ADC sample capture FIFO: buffers strobed ADC samples, flags overflow and a
// fill-level interrupt, and counts accepted samples.
module adc_capture #(
  parameter int dw        = 8,
  parameter int aw        = 4,
  parameter int threshold = 8
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          enable,
  input  logic [dw-1:0] adc_data,
  input  logic          adc_data_ready,
  input  logic          flush,
  input  logic          clr_ovf,
  input  logic          rd_en,
  output logic [dw-1:0] rd_data,
  output logic          rd_valid,
  output logic [aw:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          irq,
  output logic [15:0]   sample_cnt
);

  localparam int depth = 1 << aw;

  logic [dw-1:0] mem [depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic          wr_event;
  logic          rd_acc;
  logic          wr_acc;
  logic          drop;

  assign empty = (count == '0);
  assign full  = (count == (aw+1)'(depth));
  assign irq   = (count >= (aw+1)'(threshold));

  // A read in the same cycle frees the slot a write into a full FIFO needs;
  // reads of an empty FIFO are never accepted, so there is no fall-through.
  assign wr_event = adc_data_ready & enable & ~flush;
  assign rd_acc   = rd_en & ~empty & ~flush;
  assign wr_acc   = wr_event & (~full | rd_acc);
  assign drop     = wr_event & full & ~rd_acc;

  // NOTE: storage has no reset; pointers and count define what is valid, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge wb_clk) begin
    if (wr_acc) mem[wr_ptr] <= adc_data;
  end

  // NOTE: all state uses non-blocking assignments so a same-cycle write to the
  // head slot of a full FIFO still returns the old head entry on the read.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr];
      if (wr_acc) sample_cnt <= sample_cnt + 16'd1;

      // A new drop wins over a coincident clear.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: a queue-based FIFO model predicts every
// popped sample and the status outputs; a monitor compares after each edge.
module tb_adc_capture;

  localparam int dw = 8;
  localparam int aw = 4;
  localparam int depth = 16;
  localparam int thr = 8;

  logic          wb_clk = 1'b0;
  logic          wb_rst_n;
  logic          enable;
  logic [dw-1:0] adc_data;
  logic          adc_data_ready;
  logic          flush;
  logic          clr_ovf;
  logic          rd_en;
  logic [dw-1:0] rd_data;
  logic          rd_valid;
  logic [aw:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          irq;
  logic [15:0]   sample_cnt;

  adc_capture #(.dw(dw), .aw(aw), .threshold(thr)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .enable(enable),
    .adc_data(adc_data), .adc_data_ready(adc_data_ready), .flush(flush),
    .clr_ovf(clr_ovf), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .empty(empty), .full(full), .overflow(overflow),
    .irq(irq), .sample_cnt(sample_cnt)
  );

  always #5 wb_clk = ~wb_clk;

  // Reference model state.
  logic [dw-1:0] fifo_q[$];
  logic [dw-1:0] exp_q[$];
  logic          m_ovf;
  logic [15:0]   m_scnt;
  logic [dw-1:0] m_rd_data;
  logic          m_rd_valid;
  logic          mon_on = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_scnt = '0;
    m_rd_data = '0;
    m_rd_valid = 1'b0;
  endtask

  // One clock of stimulus; the model is advanced by the same inputs.
  task automatic step(input logic rdy, input logic [dw-1:0] d, input logic en,
                      input logic rd, input logic fl, input logic clr);
    bit wr, rd_ok, had_room;
    @(negedge wb_clk);
    adc_data_ready = rdy; adc_data = d; enable = en;
    rd_en = rd; flush = fl; clr_ovf = clr;
    wr       = rdy && en && !fl;
    rd_ok    = rd && fifo_q.size() > 0 && !fl;
    had_room = fifo_q.size() < depth;
    m_rd_valid = rd_ok;
    if (fl) fifo_q.delete();
    if (rd_ok) begin
      m_rd_data = fifo_q.pop_front();
      exp_q.push_back(m_rd_data);
    end
    if (wr && (had_room || rd_ok)) begin
      fifo_q.push_back(d);
      m_scnt++;
    end
    if (wr && !had_room && !rd_ok) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 0);
  endtask

  task automatic pop_all();
    while (fifo_q.size() > 0) step(0, 0, 1, 1, 0, 0);
    idle(2);
  endtask

  // Monitor: pops the scoreboard on every rd_valid and tracks status outputs.
  initial begin
    forever begin
      @(posedge wb_clk);
      #1;
      if (mon_on) begin
        if (rd_valid) begin
          if (exp_q.size() == 0) check("unexpected_rd_valid", 1, 0);
          else check("rd_data_pop", rd_data, exp_q.pop_front());
        end
        check("rd_valid", rd_valid, m_rd_valid);
        check("rd_data_hold", rd_data, m_rd_data);
        check("count", count, fifo_q.size());
        check("empty", empty, fifo_q.size() == 0);
        check("full", full, fifo_q.size() == depth);
        check("irq", irq, fifo_q.size() >= thr);
        check("overflow", overflow, m_ovf);
        check("sample_cnt", sample_cnt, m_scnt);
      end
    end
  end

  initial begin
    wb_rst_n = 1'b0;
    enable = 0; adc_data = 0; adc_data_ready = 0;
    flush = 0; clr_ovf = 0; rd_en = 0;
    model_reset();
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_irq", irq, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    mon_on = 1'b1;

    // Basic three-sample capture and readback.
    step(1, 8'h11, 1, 0, 0, 0);
    step(1, 8'h22, 1, 0, 0, 0);
    step(1, 8'h33, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0);
    idle(2);

    // Fill past capacity, then drain: overflow and ordering.
    for (int i = 0; i < 20; i++) step(1, 8'(8'h40 + i), 1, 0, 0, 0);
    idle(1);
    // Full plus simultaneous read: sample accepted, no overflow set.
    step(0, 0, 1, 0, 0, 1);
    step(1, 8'hAA, 1, 1, 0, 0);
    idle(1);
    pop_all();

    // irq threshold edge and read on empty.
    for (int i = 0; i < 8; i++) step(1, 8'(i + 1), 1, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 1, 0, 0);
    idle(1);
    pop_all();
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    idle(1);

    // enable low blocks writes but not reads; write+read on empty.
    step(1, 8'h77, 0, 0, 0, 0);
    step(1, 8'h78, 1, 1, 0, 0);
    step(1, 8'h79, 0, 1, 0, 0);
    idle(2);

    // Flush with a coincident strobe, then clear-vs-drop priority.
    for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 1, 0, 0, 0);
    step(1, 8'hEE, 1, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 17; i++) step(1, 8'(8'hC0 + i), 1, 0, 0, 0);
    step(1, 8'hFE, 1, 0, 0, 1);
    idle(1);
    step(0, 0, 1, 0, 0, 1);
    idle(1);
    pop_all();

    // Asynchronous reset mid-burst, between clock edges.
    for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 1, 0, 0, 0);
    step(1, 8'h64, 1, 1, 0, 0);
    #2;
    wb_rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_empty", empty, 1);
    check("async_rst_rd_valid", rd_valid, 0);
    check("async_rst_rd_data", rd_data, 0);
    check("async_rst_sample_cnt", sample_cnt, 0);
    adc_data_ready = 0; rd_en = 0;
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    step(1, 8'h5A, 1, 0, 0, 0);
    step(1, 8'h5B, 1, 0, 0, 0);
    pop_all();

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 9) != 0,
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 5);
    pop_all();

    check("scoreboard_drained", exp_q.size(), 0);
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
